// File: rtl/inv_round_core.sv
// inv_round_core: AES inverse round core, InvShiftRows + AddRoundKey at accept,
// then column-serial InvMixColumns (skipped on the final round), valid/ready output.
module inv_round_core (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_valid,
   output logic         o_ready,
   input  logic [0:127] i_state,
   input  logic [0:127] i_round_key,
   input  logic         i_last,
   output logic         o_valid,
   input  logic         i_ready,
   output logic [0:127] o_state
);
   typedef enum logic [1:0] {IDLE, MIX, DONE} state_t;
   state_t       st;
   logic [0:127] state_q;
   logic [0:127] shifted;
   logic [1:0]   col;
   logic         last_q;
   logic [0:31]  cur;
   logic [0:31]  mixed;

   function automatic logic [7:0] xt(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] c);
      logic [7:0] b2, b4, b8;
      b2 = xt(b);
      b4 = xt(b2);
      b8 = xt(b4);
      return (c[3] ? b8 : 8'h00) ^ (c[2] ? b4 : 8'h00) ^ (c[1] ? b2 : 8'h00) ^ (c[0] ? b : 8'h00);
   endfunction

   // byte k = 4*c + r takes input byte from column (c - r) mod 4, same row
   genvar k;
   for (k = 0; k < 16; k++) begin : g_shift
      assign shifted[8*k +: 8] = i_state[8*(4*(((k/4) - (k%4) + 4) % 4) + (k%4)) +: 8];
   end

   assign cur   = state_q[{col, 5'b0} +: 32];
   assign mixed = {
      mul(cur[0:7], 4'he) ^ mul(cur[8:15], 4'hb) ^ mul(cur[16:23], 4'hd) ^ mul(cur[24:31], 4'h9),
      mul(cur[0:7], 4'h9) ^ mul(cur[8:15], 4'he) ^ mul(cur[16:23], 4'hb) ^ mul(cur[24:31], 4'hd),
      mul(cur[0:7], 4'hd) ^ mul(cur[8:15], 4'h9) ^ mul(cur[16:23], 4'he) ^ mul(cur[24:31], 4'hb),
      mul(cur[0:7], 4'hb) ^ mul(cur[8:15], 4'hd) ^ mul(cur[16:23], 4'h9) ^ mul(cur[24:31], 4'he)};

   assign o_state = state_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st      <= IDLE;
         state_q <= '0;
         col     <= 2'd0;
         last_q  <= 1'b0;
         o_ready <= 1'b0;
         o_valid <= 1'b0;
      end else begin
         case (st)
            IDLE: if (i_valid && o_ready) begin
               state_q <= shifted ^ i_round_key;
               last_q  <= i_last;
               col     <= 2'd0;
               o_ready <= 1'b0;
               st      <= i_last ? DONE : MIX;
            end else o_ready <= 1'b1;
            MIX: begin
               if (!last_q) state_q[{col, 5'b0} +: 32] <= mixed;
               col <= col + 2'd1;
               if (col == 2'd3) begin
                  st      <= DONE;
                  o_valid <= 1'b1;
               end
            end
            // a final round enters DONE with o_valid low; it rises one edge later
            DONE: if (o_valid && i_ready) begin
               st      <= IDLE;
               o_valid <= 1'b0;
               o_ready <= 1'b1;
            end else o_valid <= 1'b1;
            default: st <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_inv_round_core.sv
// tb_inv_round_core: directed vectors plus random rounds against a byte-level AES model.
module tb_inv_round_core;
   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         i_valid = 1'b0;
   logic         o_ready;
   logic [0:127] i_state = '0;
   logic [0:127] i_round_key = '0;
   logic         i_last = 1'b0;
   logic         o_valid;
   logic         i_ready = 1'b0;
   logic [0:127] o_state;
   int           n_pass = 0;
   int           n_total = 0;
   logic [127:0] expq[$];

   inv_round_core dut (
      .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .o_ready(o_ready),
      .i_state(i_state), .i_round_key(i_round_key), .i_last(i_last),
      .o_valid(o_valid), .i_ready(i_ready), .o_state(o_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
         b = b >> 1;
      end
      return p;
   endfunction

   function automatic logic [0:127] model(input logic [0:127] s, input logic [0:127] key, input bit last);
      logic [7:0] a[16];
      logic [7:0] o[16];
      logic [7:0] t[4];
      logic [7:0] base[4];
      logic [0:127] r;
      base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      for (int i = 0; i < 16; i++) a[i] = s[8*i +: 8];
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++)
            o[4*c+rw] = a[4*((c - rw + 4) % 4) + rw] ^ key[8*(4*c+rw) +: 8];
      if (!last)
         for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) t[j] = o[4*c+j];
            for (int rw = 0; rw < 4; rw++) begin
               o[4*c+rw] = 8'h00;
               for (int j = 0; j < 4; j++) o[4*c+rw] = o[4*c+rw] ^ gm(base[(j - rw + 4) % 4], t[j]);
            end
         end
      for (int i = 0; i < 16; i++) r[8*i +: 8] = o[i];
      return r;
   endfunction

   function automatic logic [0:127] shift_rows(input logic [0:127] s);
      logic [0:127] r;
      for (int c = 0; c < 4; c++)
         for (int rw = 0; rw < 4; rw++)
            r[8*(4*c+rw) +: 8] = s[8*(4*((c + rw) % 4) + rw) +: 8];
      return r;
   endfunction

   function automatic logic [0:127] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic xfer(input string tag, input logic [0:127] s, input logic [0:127] key,
                       input bit last, input logic [127:0] exp);
      int n;
      n = 0;
      while (!o_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_ready"}, 128'(o_ready), 128'(1));
      i_state = s; i_round_key = key; i_last = last; i_valid = 1'b1; i_ready = 1'b1;
      @(negedge clk);
      i_valid = 1'b0; i_state = rnd128(); i_round_key = rnd128(); i_last = ~last;
      n = 0;
      while (!o_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_lat"}, 128'(n), last ? 128'(1) : 128'(4));
      check({tag, "_data"}, o_state, exp);
      @(negedge clk);
      check({tag, "_release"}, {126'd0, o_valid, o_ready}, 128'b01);
   endtask

   initial begin
      logic [0:127] s, key, hold;
      int n, acc, outs, last_t;
      repeat (3) @(negedge clk);
      check("reset_outs", {o_state, o_valid, o_ready}, '0);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_ready", {126'd0, o_valid, o_ready}, 128'b01);

      xfer("isr", 128'h000102030405060708090a0b0c0d0e0f, '0, 1'b1,
           128'h000d0a0704010e0b0805020f0c090603);
      xfer("imc", {4{32'h8e4da1bc}}, '0, 1'b0, {4{32'hdb135345}});
      s = shift_rows(128'h9fdc589d_01010101_8e4da1bc_01010101);
      xfer("mixed", s, '0, 1'b0, 128'hf20a225c_01010101_db135345_01010101);
      xfer("key_ff", '0, '1, 1'b1, '1);
      for (int i = 0; i < 8; i++) begin
         s = rnd128(); key = rnd128();
         xfer($sformatf("rnd%0d", i), s, key, i[0], model(s, key, i[0]));
      end

      // reset in the middle of MIX discards the in-flight state
      i_state = rnd128(); i_round_key = rnd128(); i_last = 1'b0; i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      #1 check("rst_mid_mix", {o_state, o_valid, o_ready}, '0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release", {126'd0, o_valid, o_ready}, 128'b01);
      repeat (5) @(negedge clk);
      check("rst_no_valid", 128'(o_valid), '0);

      // back-pressure
      s = rnd128(); key = rnd128(); hold = model(s, key, 1'b0);
      i_state = s; i_round_key = key; i_last = 1'b0; i_ready = 1'b0; i_valid = 1'b1;
      @(negedge clk);
      i_valid = 1'b0;
      n = 0;
      while (!o_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      for (int i = 0; i < 10; i++) begin
         i_valid = i[0]; i_state = rnd128(); i_round_key = rnd128();
         @(negedge clk);
         check("bp_hold", {o_state, o_valid, o_ready}, {hold, 2'b10});
      end
      i_valid = 1'b0; i_ready = 1'b1;
      @(negedge clk);
      check("bp_release", {126'd0, o_valid, o_ready}, 128'b01);
      s = rnd128(); key = rnd128();
      xfer("bp_after", s, key, 1'b0, model(s, key, 1'b0));

      // back-to-back: accept at E0, valid after E4, handshake E5, next accept E6
      acc = 0; outs = 0; last_t = 0;
      i_state = rnd128(); i_round_key = rnd128(); i_last = 1'b0; i_ready = 1'b1; i_valid = 1'b1;
      for (int t = 0; t < 60 && outs < 3; t++) begin
         if (o_valid) begin
            check("b2b_data", o_state, expq.size() > 0 ? expq.pop_front() : 'x);
            outs++;
         end
         if (o_ready && i_valid) begin
            expq.push_back(model(i_state, i_round_key, 1'b0));
            if (acc > 0) check("b2b_gap", 128'(t - last_t), 128'(6));
            last_t = t;
            acc++;
         end else if (!o_ready) begin
            if (acc == 3) i_valid = 1'b0;
            else begin
               i_state = rnd128(); i_round_key = rnd128();
            end
         end
         @(negedge clk);
      end
      check("b2b_count", 128'(outs), 128'(3));

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: run did not finish");
      $fatal(1);
   end
endmodule
